// File: rtl/egress_sched_voq.sv
// Multi-queue pointer VOQ: NUM_Q FIFOs with an RR/strict scheduler feeding a registered valid/ready slot.
// Pointer visible 1 cycle after its write edge; a stalled slot holds ptr_o/ptr_qid_o and blocks every pop.
module egress_sched_voq #(
  parameter int ADDR_W     = 6,
  parameter int NUM_Q      = 4,
  parameter int DEPTH      = 16,
  parameter int SCHED_MODE = 0,
  parameter int CNT_W      = 16,
  localparam int QID_W     = ($clog2(NUM_Q) > 1) ? $clog2(NUM_Q) : 1,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                   switch_clk,
  input  logic                   switch_rst_n,
  input  logic                   wr_req_i,
  input  logic [QID_W-1:0]       wr_qid_i,
  input  logic [ADDR_W-1:0]      wr_ptr_i,
  output logic                   wr_drop_o,
  output logic                   ptr_valid_o,
  output logic [ADDR_W-1:0]      ptr_o,
  output logic [QID_W-1:0]       ptr_qid_o,
  input  logic                   ptr_ready_i,
  output logic [NUM_Q-1:0]       q_empty_o,
  output logic [NUM_Q-1:0]       q_full_o,
  output logic [NUM_Q*LVL_W-1:0] q_level_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [QID_W:0]   NUM_Q_L = (QID_W+1)'(NUM_Q);

  logic [ADDR_W-1:0] mem_q    [NUM_Q][DEPTH];
  logic [LVL_W-1:0]  cnt_q    [NUM_Q];
  logic [LVL_W-1:0]  cnt_d    [NUM_Q];
  logic [IDX_W-1:0]  rd_idx_q [NUM_Q];
  logic [IDX_W-1:0]  wr_idx_q [NUM_Q];
  logic [QID_W-1:0]  last_q;
  logic [QID_W-1:0]  gnt;
  logic [QID_W:0]    cand;
  logic              found;
  logic              in_range;
  logic              load_en;
  logic              pop;
  logic              drop;
  logic [NUM_Q-1:0]  ne_vec;
  logic [NUM_Q-1:0]  push_vec;
  logic [NUM_Q-1:0]  pop_vec;
  logic              ptr_valid_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [QID_W-1:0]  ptr_qid_q;
  logic              wr_drop_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  always_comb begin
    gnt      = '0;
    cand     = '0;
    found    = 1'b0;
    in_range = ({1'b0, wr_qid_i} < NUM_Q_L);
    for (int i = 0; i < NUM_Q; i++) ne_vec[i] = (cnt_q[i] != '0);
    load_en = !ptr_valid_q || ptr_ready_i;
    pop     = load_en && (|ne_vec);
    if (SCHED_MODE == 1) begin
      for (int i = NUM_Q - 1; i >= 0; i--) begin
        if (ne_vec[i]) gnt = QID_W'(i);
      end
    end else begin
      // Rotate from the queue after the last pop; explicit wrap handles non-power-of-2 NUM_Q.
      for (int k = 1; k <= NUM_Q; k++) begin
        cand = {1'b0, last_q} + (QID_W+1)'(k);
        if (cand >= NUM_Q_L) cand = cand - NUM_Q_L;
        if (!found && ne_vec[cand[QID_W-1:0]]) begin
          gnt   = cand[QID_W-1:0];
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_Q; i++) begin
      // Full check uses the registered count, so a same-cycle pop never frees room for the push.
      push_vec[i] = wr_req_i && in_range && (wr_qid_i == QID_W'(i)) && (cnt_q[i] != DEPTH_L);
      pop_vec[i]  = pop && (gnt == QID_W'(i));
      case ({push_vec[i], pop_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + LVL_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - LVL_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    drop = wr_req_i && !(|push_vec);
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      for (int i = 0; i < NUM_Q; i++) begin
        cnt_q[i]    <= '0;
        rd_idx_q[i] <= '0;
        wr_idx_q[i] <= '0;
      end
      last_q      <= QID_W'(NUM_Q - 1);
      ptr_valid_q <= 1'b0;
      ptr_q       <= '0;
      ptr_qid_q   <= '0;
      wr_drop_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push_vec[i]) wr_idx_q[i] <= wr_idx_q[i] + IDX_W'(1);
        if (pop_vec[i])  rd_idx_q[i] <= rd_idx_q[i] + IDX_W'(1);
      end
      if (pop) begin
        ptr_valid_q <= 1'b1;
        ptr_q       <= mem_q[gnt][rd_idx_q[gnt]];
        ptr_qid_q   <= gnt;
        last_q      <= gnt;
      end else if (load_en) begin
        ptr_valid_q <= 1'b0;
      end
      wr_drop_q <= drop;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge switch_clk) begin
    for (int i = 0; i < NUM_Q; i++) begin
      if (push_vec[i]) mem_q[i][wr_idx_q[i]] <= wr_ptr_i;
    end
  end

  for (genvar g = 0; g < NUM_Q; g++) begin : g_status
    assign q_empty_o[g]                 = (cnt_q[g] == '0);
    assign q_full_o[g]                  = (cnt_q[g] == DEPTH_L);
    assign q_level_o[g*LVL_W +: LVL_W]  = cnt_q[g];
  end

  assign wr_drop_o   = wr_drop_q;
  assign ptr_valid_o = ptr_valid_q;
  assign ptr_o       = ptr_q;
  assign ptr_qid_o   = ptr_qid_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_egress_sched_voq.sv
// Directed bench for egress_sched_voq: RR, strict-priority and NUM_Q=3 instances share one stimulus stream.
module tb_egress_sched_voq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [1:0]  wr_qid = '0;
  logic [5:0]  wr_ptr = '0;
  logic        rdy = 1'b0;

  logic        a_vld, s_vld, t_vld;
  logic [5:0]  a_ptr, s_ptr, t_ptr;
  logic [1:0]  a_qid, s_qid, t_qid;
  logic        a_drop, s_drop, t_drop;
  logic [3:0]  a_emp, a_full, s_emp, s_full;
  logic [2:0]  t_emp, t_full;
  logic [19:0] a_lvl, s_lvl;
  logic [14:0] t_lvl;
  logic [15:0] a_cnt, s_cnt, t_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  egress_sched_voq #(.SCHED_MODE(0)) u_rr (
    .switch_clk(clk), .switch_rst_n(rst_n), .wr_req_i(wr_req), .wr_qid_i(wr_qid), .wr_ptr_i(wr_ptr),
    .wr_drop_o(a_drop), .ptr_valid_o(a_vld), .ptr_o(a_ptr), .ptr_qid_o(a_qid), .ptr_ready_i(rdy),
    .q_empty_o(a_emp), .q_full_o(a_full), .q_level_o(a_lvl), .drop_cnt_o(a_cnt));

  egress_sched_voq #(.SCHED_MODE(1)) u_sp (
    .switch_clk(clk), .switch_rst_n(rst_n), .wr_req_i(wr_req), .wr_qid_i(wr_qid), .wr_ptr_i(wr_ptr),
    .wr_drop_o(s_drop), .ptr_valid_o(s_vld), .ptr_o(s_ptr), .ptr_qid_o(s_qid), .ptr_ready_i(rdy),
    .q_empty_o(s_emp), .q_full_o(s_full), .q_level_o(s_lvl), .drop_cnt_o(s_cnt));

  egress_sched_voq #(.NUM_Q(3)) u_q3 (
    .switch_clk(clk), .switch_rst_n(rst_n), .wr_req_i(wr_req), .wr_qid_i(wr_qid), .wr_ptr_i(wr_ptr),
    .wr_drop_o(t_drop), .ptr_valid_o(t_vld), .ptr_o(t_ptr), .ptr_qid_o(t_qid), .ptr_ready_i(rdy),
    .q_empty_o(t_emp), .q_full_o(t_full), .q_level_o(t_lvl), .drop_cnt_o(t_cnt));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    rdy    = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({a_vld, a_ptr, a_qid, a_drop} !== 10'd0) begin errors++; $display("FAIL rst_slot got %h exp 000", {a_vld, a_ptr, a_qid, a_drop}); end
    checks++; if ({a_emp, a_full} !== 8'hF0) begin errors++; $display("FAIL rst_empty_full got %h exp f0", {a_emp, a_full}); end
    checks++; if (a_lvl !== 20'd0) begin errors++; $display("FAIL rst_level got %h exp 0", a_lvl); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL rst_dropcnt got %h exp 0", a_cnt); end
    checks++; if ({t_emp, s_emp} !== 7'h7F) begin errors++; $display("FAIL rst_empty_others got %h exp 7f", {t_emp, s_emp}); end
  endtask

  task automatic test_basic();
    do_reset();
    rdy = 1'b1; wr_req = 1'b1; wr_qid = 2'd2; wr_ptr = 6'h15;
    tick();
    wr_req = 1'b0;
    checks++; if ({a_vld, a_lvl[14:10]} !== {1'b0, 5'd1}) begin errors++; $display("FAIL basic_count got %h exp 01", {a_vld, a_lvl[14:10]}); end
    tick();
    checks++; if ({a_vld, a_ptr, a_qid} !== {1'b1, 6'h15, 2'd2}) begin errors++; $display("FAIL basic_out got %h exp %h", {a_vld, a_ptr, a_qid}, {1'b1, 6'h15, 2'd2}); end
    checks++; if (a_lvl !== 20'd0) begin errors++; $display("FAIL basic_popped got %h exp 0", a_lvl); end
    tick();
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", a_vld); end
  endtask

  task automatic test_sched();
    logic [1:0] pre_q [5] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
    logic [5:0] rr_p [6] = '{6'd1, 6'd3, 6'd4, 6'd2, 6'd5, 6'd6};
    logic [1:0] rr_q [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0};
    logic [5:0] sp_p [6] = '{6'd1, 6'd2, 6'd3, 6'd6, 6'd4, 6'd5};
    logic [1:0] sp_q [6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_qid = pre_q[i]; wr_ptr = 6'(i + 1);
      tick();
    end
    wr_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if ({a_vld, a_ptr, a_qid} !== {1'b1, rr_p[k], rr_q[k]}) begin errors++; $display("FAIL rr_order[%0d] got %h exp %h", k, {a_vld, a_ptr, a_qid}, {1'b1, rr_p[k], rr_q[k]}); end
      checks++; if ({s_vld, s_ptr, s_qid} !== {1'b1, sp_p[k], sp_q[k]}) begin errors++; $display("FAIL sp_order[%0d] got %h exp %h", k, {s_vld, s_ptr, s_qid}, {1'b1, sp_p[k], sp_q[k]}); end
      rdy = 1'b1;
      if (k == 1) begin wr_req = 1'b1; wr_qid = 2'd0; wr_ptr = 6'd6; end
      else wr_req = 1'b0;
      tick();
    end
    checks++; if ({a_vld, s_vld} !== 2'b00) begin errors++; $display("FAIL sched_drained got %b exp 00", {a_vld, s_vld}); end
  endtask

  task automatic test_backpressure();
    do_reset();
    wr_req = 1'b1; wr_qid = 2'd1; wr_ptr = 6'h07;
    tick();
    wr_ptr = 6'h08;
    tick();
    wr_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({a_vld, a_ptr, a_qid, a_lvl} !== {1'b1, 6'h07, 2'd1, 20'h00020}) begin errors++; $display("FAIL bp_hold[%0d] got %h exp %h", c, {a_vld, a_ptr, a_qid, a_lvl}, {1'b1, 6'h07, 2'd1, 20'h00020}); end
      tick();
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    checks++; if ({a_vld, a_ptr, a_lvl} !== {1'b1, 6'h08, 20'd0}) begin errors++; $display("FAIL bp_step got %h exp %h", {a_vld, a_ptr, a_lvl}, {1'b1, 6'h08, 20'd0}); end
    tick();
    checks++; if ({a_vld, a_ptr} !== {1'b1, 6'h08}) begin errors++; $display("FAIL bp_one_only got %h exp %h", {a_vld, a_ptr}, {1'b1, 6'h08}); end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      wr_req = 1'b1; wr_qid = 2'd1; wr_ptr = 6'(i + 32);
      tick();
      checks++; if (a_drop !== (i == 17)) begin errors++; $display("FAIL full_drop_pulse[%0d] got %b exp %b", i, a_drop, (i == 17)); end
    end
    checks++; if ({a_full[1], a_lvl[9:5], a_cnt} !== {1'b1, 5'd16, 16'd1}) begin errors++; $display("FAIL full_state got %h exp %h", {a_full[1], a_lvl[9:5], a_cnt}, {1'b1, 5'd16, 16'd1}); end
    wr_ptr = 6'h3F; rdy = 1'b1;
    tick();
    wr_req = 1'b0; rdy = 1'b0;
    checks++; if ({a_drop, a_cnt, a_lvl[9:5], a_full[1]} !== {1'b1, 16'd2, 5'd15, 1'b0}) begin errors++; $display("FAIL full_push_pop got %h exp %h", {a_drop, a_cnt, a_lvl[9:5], a_full[1]}, {1'b1, 16'd2, 5'd15, 1'b0}); end
    checks++; if (a_ptr !== 6'h21) begin errors++; $display("FAIL full_pop_ptr got %h exp 21", a_ptr); end
    tick();
    checks++; if ({a_drop, a_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL full_drop_clear got %h exp %h", {a_drop, a_cnt}, {1'b0, 16'd2}); end
  endtask

  task automatic test_qid_range();
    do_reset();
    wr_req = 1'b1; wr_qid = 2'd3; wr_ptr = 6'h09;
    tick();
    wr_req = 1'b0;
    checks++; if ({t_drop, t_cnt, t_emp} !== {1'b1, 16'd1, 3'b111}) begin errors++; $display("FAIL qid_drop got %h exp %h", {t_drop, t_cnt, t_emp}, {1'b1, 16'd1, 3'b111}); end
    checks++; if ({a_drop, a_lvl[19:15]} !== {1'b0, 5'd1}) begin errors++; $display("FAIL qid_accept4 got %h exp 01", {a_drop, a_lvl[19:15]}); end
    tick();
    checks++; if ({t_drop, t_vld, a_vld, a_ptr, a_qid} !== {1'b0, 1'b0, 1'b1, 6'h09, 2'd3}) begin errors++; $display("FAIL qid_after got %h exp %h", {t_drop, t_vld, a_vld, a_ptr, a_qid}, {1'b0, 1'b0, 1'b1, 6'h09, 2'd3}); end
  endtask

  task automatic test_wrap_reset();
    int got;
    do_reset();
    rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 42; c++) begin
      if (c < 40) begin wr_req = 1'b1; wr_qid = 2'd0; wr_ptr = 6'(c); end
      else wr_req = 1'b0;
      tick();
      if (a_vld) begin
        checks++; if (a_ptr !== 6'(got)) begin errors++; $display("FAIL wrap_order[%0d] got %h exp %h", got, a_ptr, 6'(got)); end
        got++;
      end
    end
    checks++; if (got !== 40) begin errors++; $display("FAIL wrap_total got %0d exp 40", got); end
    rdy = 1'b0;
    wr_req = 1'b1; wr_qid = 2'd1; wr_ptr = 6'd9;  tick();
    wr_ptr = 6'd10; tick();
    wr_qid = 2'd0; wr_ptr = 6'd11; tick();
    wr_req = 1'b0;
    checks++; if ({a_vld, a_ptr, a_qid} !== {1'b1, 6'd9, 2'd1}) begin errors++; $display("FAIL prerst_slot got %h exp %h", {a_vld, a_ptr, a_qid}, {1'b1, 6'd9, 2'd1}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_vld, a_ptr, a_qid, a_emp, a_lvl} !== {9'd0, 4'hF, 20'd0}) begin errors++; $display("FAIL async_rst got %h exp %h", {a_vld, a_ptr, a_qid, a_emp, a_lvl}, {9'd0, 4'hF, 20'd0}); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if ({a_vld, a_emp} !== {1'b0, 4'hF}) begin errors++; $display("FAIL postrst_idle got %h exp 0f", {a_vld, a_emp}); end
    wr_req = 1'b1; wr_qid = 2'd0; wr_ptr = 6'h2A;
    tick();
    wr_req = 1'b0;
    tick();
    checks++; if ({a_vld, a_ptr, a_qid} !== {1'b1, 6'h2A, 2'd0}) begin errors++; $display("FAIL postrst_grant got %h exp %h", {a_vld, a_ptr, a_qid}, {1'b1, 6'h2A, 2'd0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sched();
    test_backpressure();
    test_full_drop();
    test_qid_range();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
